// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stall encoding, stage action enum and default EX/MEM and MADD widths
package pipe_pkg;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  typedef enum logic [2:0] {ACT_RESET, ACT_FLUSH, ACT_BUBBLE, ACT_ADV, ACT_HOLD} act_e;
  localparam int EXMEM_DATA_W = 103;
  localparam int MADD_CTX_W = 66;
  localparam int DEF_STALL_W = 6;
  localparam int DEF_STAGE = 3;
  localparam int DEF_CNT_W = 32;
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: W-bit counter that sticks at all-ones; ports clk, clr (sync clear), inc, cnt
module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: stall/flush-aware inter-stage register with valid bit and context feedback
//   in : clk, rst (sync, active-high), stall[STALL_W], flush, in_valid, in_data[DATA_W], ctx_i[CTX_W]
//   out: out_valid, out_data[DATA_W], ctx_o[CTX_W]
//   PIPE_PERF_EN adds saturating bubble_cnt, hold_cnt, flush_cnt[CNT_W]
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = EXMEM_DATA_W,
  parameter int                CTX_W    = MADD_CTX_W,
  parameter int                STALL_W  = DEF_STALL_W,
  parameter int                STAGE    = DEF_STAGE,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int                CNT_W    = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTX_W-1:0]   ctx_i,
`ifdef PIPE_PERF_EN
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
`endif
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTX_W-1:0]   ctx_o
);
  if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
  end
  localparam logic [STALL_W-1:0] CUR_M = STALL_W'(1) << STAGE;
  localparam logic [STALL_W-1:0] NXT_M = CUR_M << 1;
  logic cur_stop, nxt_stop;
  act_e act;
  assign cur_stop = |(stall & CUR_M);
  assign nxt_stop = |(stall & NXT_M);
  // Stopped upstream with a free downstream is a bubble; stall[STAGE+1] alone is treated as advance
  always_comb
    act = rst ? ACT_RESET :
          flush ? ACT_FLUSH :
          cur_stop != STOP ? ACT_ADV :
          nxt_stop == STOP ? ACT_HOLD : ACT_BUBBLE;
  always_ff @(posedge clk) begin
    out_valid <= act == ACT_ADV ? in_valid : act == ACT_HOLD ? out_valid : 1'b0;
    out_data  <= act == ACT_ADV ? in_data : act == ACT_HOLD ? out_data : NOP_DATA;
    ctx_o     <= (act == ACT_BUBBLE || act == ACT_HOLD) ? ctx_i : '0;
  end
`ifdef PIPE_PERF_EN
  pipe_sat_cnt #(.W(CNT_W)) u_bubble (.clk(clk), .clr(rst), .inc(act == ACT_BUBBLE), .cnt(bubble_cnt));
  pipe_sat_cnt #(.W(CNT_W)) u_hold   (.clk(clk), .clr(rst), .inc(act == ACT_HOLD),   .cnt(hold_cnt));
  pipe_sat_cnt #(.W(CNT_W)) u_flush  (.clk(clk), .clr(rst), .inc(act == ACT_FLUSH),  .cnt(flush_cnt));
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: random and directed stimulus checked against a behavioural stage model
module tb_pipe_stage_reg;
  localparam int DW = 103;
  localparam int CW = 66;
  localparam int SW = 6;
  localparam int ST = 3;
  localparam int NW = 4;
  localparam int CMAX = 15;
  logic clk = 1'b0;
  logic rst, flush, in_valid;
  logic [SW-1:0] stall;
  logic [DW-1:0] in_data;
  logic [CW-1:0] ctx_i;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] ctx_o;
`ifdef PIPE_PERF_EN
  logic [NW-1:0] bubble_cnt, hold_cnt, flush_cnt;
`endif
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(DW), .CTX_W(CW), .STALL_W(SW), .STAGE(ST), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .ctx_i(ctx_i),
`ifdef PIPE_PERF_EN
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt), .flush_cnt(flush_cnt),
`endif
    .out_valid(out_valid), .out_data(out_data), .ctx_o(ctx_o)
  );
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask
  bit seen_rst = 0;
  bit m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ctx;
  int m_bub, m_hold, m_flush;
  // Stage behaviour straight from the action priority list
  always @(posedge clk) begin
    if (rst) begin
      seen_rst = 1;
      m_valid = 0; m_data = '0; m_ctx = '0;
      m_bub = 0; m_hold = 0; m_flush = 0;
    end else if (flush) begin
      m_valid = 0; m_data = '0; m_ctx = '0;
      m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    end else if (stall[ST] && !stall[ST+1]) begin
      m_valid = 0; m_data = '0; m_ctx = ctx_i;
      m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
    end else if (!stall[ST]) begin
      m_valid = in_valid; m_data = in_data; m_ctx = '0;
    end else begin
      m_ctx = ctx_i;
      m_hold = (m_hold < CMAX) ? m_hold + 1 : CMAX;
    end
  end
  always @(negedge clk) if (seen_rst) begin
    chk("m_valid", 128'(out_valid), 128'(m_valid));
    chk("m_data", 128'(out_data), 128'(m_data));
    chk("m_ctx", 128'(ctx_o), 128'(m_ctx));
`ifdef PIPE_PERF_EN
    chk("m_bub", 128'(bubble_cnt), 128'(m_bub));
    chk("m_hold", 128'(hold_cnt), 128'(m_hold));
    chk("m_flush", 128'(flush_cnt), 128'(m_flush));
`endif
  end
  task automatic drive(input logic r, input logic f, input logic [SW-1:0] s, input logic v,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
    rst = r; flush = f; stall = s; in_valid = v; in_data = d; ctx_i = c;
    @(posedge clk);
    #1;
  endtask
  logic [127:0] rnd;
  initial begin
    drive(1, 0, '0, 0, '0, '0);
    drive(1, 1, '0, 1, 103'h55, 66'h7);
    chk("rst_valid", 128'(out_valid), 128'h0);
    chk("rst_data", 128'(out_data), 128'h0);
    chk("rst_ctx", 128'(ctx_o), 128'h0);
    drive(0, 0, '0, 1, 103'h1234, 66'h9);
    chk("adv_valid", 128'(out_valid), 128'h1);
    chk("adv_data", 128'(out_data), 128'h1234);
    chk("adv_ctx", 128'(ctx_o), 128'h0);
    drive(0, 0, 6'b001111, 1, 103'h777, 66'h2_AAAA_5555);
    chk("bub_valid", 128'(out_valid), 128'h0);
    chk("bub_data", 128'(out_data), 128'h0);
    chk("bub_ctx", 128'(ctx_o), 128'h2_AAAA_5555);
`ifdef PIPE_PERF_EN
    chk("bub_cnt1", 128'(bubble_cnt), 128'h1);
`endif
    drive(0, 0, '0, 1, 103'hBEEF, '0);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 6'b011111, 0, 103'hDEAD, CW'(k));
      chk("hold_data", 128'(out_data), 128'hBEEF);
      chk("hold_valid", 128'(out_valid), 128'h1);
      chk("hold_ctx", 128'(ctx_o), 128'(k));
    end
`ifdef PIPE_PERF_EN
    chk("hold_cnt3", 128'(hold_cnt), 128'h3);
`endif
    drive(0, 1, 6'b011111, 1, 103'hF00D, 66'h3);
    chk("fl_valid", 128'(out_valid), 128'h0);
    chk("fl_data", 128'(out_data), 128'h0);
    chk("fl_ctx", 128'(ctx_o), 128'h0);
`ifdef PIPE_PERF_EN
    chk("fl_cnt1", 128'(flush_cnt), 128'h1);
`endif
    drive(0, 0, '0, 1, 103'hABC, '0);
    drive(1, 1, 6'b011111, 1, 103'h1, 66'h1);
    chk("rf_valid", 128'(out_valid), 128'h0);
    chk("rf_data", 128'(out_data), 128'h0);
    chk("rf_ctx", 128'(ctx_o), 128'h0);
`ifdef PIPE_PERF_EN
    chk("rf_bub", 128'(bubble_cnt), 128'h0);
    chk("rf_hold", 128'(hold_cnt), 128'h0);
    chk("rf_flush", 128'(flush_cnt), 128'h0);
`endif
    for (int k = 0; k < 20; k++) drive(0, 0, 6'b001111, 1, 103'h5, CW'(k));
    chk("sat_ctx", 128'(ctx_o), 128'd19);
`ifdef PIPE_PERF_EN
    chk("sat_bub", 128'(bubble_cnt), 128'hF);
`endif
    drive(0, 0, 6'b010000, 1, 103'h4242, 66'h3);
    chk("ill_data", 128'(out_data), 128'h4242);
    chk("ill_ctx", 128'(ctx_o), 128'h0);
    for (int k = 0; k < 400; k++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), SW'($urandom()),
            1'($urandom()), rnd[DW-1:0], {rnd[CW-1:0]} ^ CW'($urandom()));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
